// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add unsigned multiplier that borrows the Execute-stage ALU for its adds.
// Optional abort port is compiled in when MUL_SEQ_ABORT_EN is defined.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_Multiplicand,
  input  logic [WIDTH-1:0] i_Multiplier,
`ifdef MUL_SEQ_ABORT_EN
  input  logic             i_Abort,
`endif
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Product_Hi,
  output logic [WIDTH-1:0] o_Product_Lo,
  output logic [WIDTH-1:0] o_ALU_Op1,
  output logic [WIDTH-1:0] o_ALU_Op2,
  output logic [2:0]       o_ALU_Ctrl,
  output logic             o_ALU_CC_WE,
  input  logic [WIDTH-1:0] i_ALU_Rslt,
  input  logic             i_ALU_Carry
);

  localparam logic [2:0] AluNop = 3'b000;
  localparam logic [2:0] AluAdd = 3'b001;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic [WIDTH-1:0]   prod_lo_q;

  logic               abort;
  logic               add_en;
  logic               last_iter;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

`ifdef MUL_SEQ_ABORT_EN
  assign abort = i_Abort;
`else
  assign abort = 1'b0;
`endif

  // The ALU is only asked to add when the current multiplier bit is set.
  assign add_en    = (state_q == StRun) && lo_q[0] && !abort;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    sum = {1'b0, hi_q};
    if (add_en) begin
      sum = {i_ALU_Carry, i_ALU_Rslt};
    end
    // Carry enters the top of hi, so the (2*WIDTH+1)-bit value shifts right by one.
    {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
  end

  assign o_ALU_Op1    = hi_q;
  assign o_ALU_Op2    = mcand_q;
  assign o_ALU_Ctrl   = add_en ? AluAdd : AluNop;
  assign o_ALU_CC_WE  = add_en;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Product_Hi = prod_hi_q;
  assign o_Product_Lo = prod_lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (i_Start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            mcand_q <= i_Multiplicand;
            lo_q    <= i_Multiplier;
            hi_q    <= '0;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          if (abort) begin
            // Product registers deliberately keep the previous result.
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              state_q   <= StDone;
              done_q    <= 1'b1;
              prod_hi_q <= hi_d;
              prod_lo_q <= lo_d;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
